// File: rtl/alpha_pkg.sv
// Shared types and constants for the alpha gain path: sample widths,
// the combiner FSM state encoding and the linearising scale helper.
package alpha_pkg;

   localparam int DATA_W     = 9;
   localparam int GAIN_SHIFT = 4;
   localparam int OUT_W      = DATA_W + GAIN_SHIFT;

   typedef logic signed [DATA_W-1:0] sample_t;
   typedef logic signed [OUT_W-1:0]  lin_sample_t;

   typedef enum logic {
      TRACK  = 1'b0,
      SETTLE = 1'b1
   } combiner_state_t;

   // Sign-extend a raw sample and, when the analog gain was reduced,
   // multiply by 2^GAIN_SHIFT so both gain modes land on one linear scale.
   // OUT_W is wide enough that neither branch can overflow.
   function automatic lin_sample_t scale_sample(input sample_t s, input logic reduced_gain);
      lin_sample_t ext;
      ext = {{GAIN_SHIFT{s[DATA_W-1]}}, s};
      return reduced_gain ? (ext <<< GAIN_SHIFT) : ext;
   endfunction

endpackage

// File: rtl/alpha_delay_line.sv
// Strobe-gated shift register that delays the alpha decision so it lines
// up with the sample it actually affected, plus a flag marking strobes on
// which the aligned alpha differs from the one used on the previous strobe.
module alpha_delay_line #(
   parameter int DEPTH = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_strobe,
   input  logic i_alpha,
   output logic o_alpha_aligned,
   output logic o_change
);

   logic [DEPTH-1:0] r_stages;
   logic             r_prev_aligned;
   logic             w_aligned;

   assign w_aligned       = r_stages[DEPTH-1];
   assign o_alpha_aligned = w_aligned;
   // Combinational so the combiner can act on the change in the same strobe.
   assign o_change        = i_strobe & (w_aligned ^ r_prev_aligned);

   generate
      if (DEPTH == 1) begin : g_single
         // Single stage: alpha from one strobe governs the next strobe.
         always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst)         r_stages <= '0;
            else if (i_strobe) r_stages <= i_alpha;
         end
      end else begin : g_multi
         // Shift alpha towards the oldest stage once per strobe.
         always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst)         r_stages <= '0;
            else if (i_strobe) r_stages <= {r_stages[DEPTH-2:0], i_alpha};
         end
      end
   endgenerate

   // Remember the aligned alpha used on this strobe for the next comparison.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)         r_prev_aligned <= 1'b0;
      else if (i_strobe) r_prev_aligned <= w_aligned;
   end

endmodule

// File: rtl/alpha_gain_combiner.sv
// Linearises the dual-gain HDR sample stream: aligns alpha with the data,
// rescales each sample onto one code range, and holds the output while the
// analog front end settles after a gain switch.
//
// Output handshake: there is no backpressure. data_valid is a one-clk pulse
// on the clk after every strobe, and data_out is stable from that edge until
// the next pulse; a consumer simply captures data_out whenever data_valid=1.
module alpha_gain_combiner
   import alpha_pkg::*;
#(
   parameter int ALPHA_DELAY    = 2,
   parameter int SETTLE_SAMPLES = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable_sampling,
   input  logic [DATA_W-1:0] hdr_current_value,
   input  logic              alpha,
   output logic [OUT_W-1:0]  data_out,
   output logic              data_valid,
   output logic              alpha_aligned,
   output logic              holding,
   output logic [7:0]        switch_count,
   output logic              dbg_state
);

   // The switch strobe itself is the first held sample, so the counter only
   // tracks the additional held strobes that follow it.
   localparam logic [2:0] SETTLE_RELOAD = (SETTLE_SAMPLES > 0) ? 3'(SETTLE_SAMPLES - 1) : 3'd0;

   combiner_state_t r_state;
   logic [2:0]      r_settle_cnt;
   lin_sample_t     r_data;
   logic            r_valid;
   logic            r_holding;
   logic [7:0]      r_switch_count;

   logic            w_alpha_aligned;
   logic            w_change;
   lin_sample_t     w_scaled;

   alpha_delay_line #(
      .DEPTH (ALPHA_DELAY)
   ) u_delay (
      .i_clk           (clk),
      .i_rst           (reset),
      .i_strobe        (enable_sampling),
      .i_alpha         (alpha),
      .o_alpha_aligned (w_alpha_aligned),
      .o_change        (w_change)
   );

   assign w_scaled = scale_sample(hdr_current_value, w_alpha_aligned);

   // Valid pulse follows each strobe by one clk, regardless of FSM state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_valid <= 1'b0;
      else       r_valid <= enable_sampling;
   end

   // Saturating count of aligned gain changes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_switch_count <= 8'd0;
      else if (w_change && (r_switch_count != 8'hFF))
         r_switch_count <= r_switch_count + 8'd1;
   end

   // Track/settle FSM: scale normally, or freeze data_out across a gain switch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= TRACK;
         r_settle_cnt <= 3'd0;
         r_data       <= '0;
         r_holding    <= 1'b0;
      end else if (enable_sampling) begin
         case (r_state)
            TRACK: begin
               if (w_change && (SETTLE_SAMPLES > 0)) begin
                  r_state      <= SETTLE;
                  r_settle_cnt <= SETTLE_RELOAD;
                  r_holding    <= 1'b1;
               end else begin
                  r_data    <= w_scaled;
                  r_holding <= 1'b0;
               end
            end
            SETTLE: begin
               if (w_change) begin
                  r_settle_cnt <= SETTLE_RELOAD;
                  r_holding    <= 1'b1;
               end else if (r_settle_cnt == 3'd0) begin
                  r_state   <= TRACK;
                  r_data    <= w_scaled;
                  r_holding <= 1'b0;
               end else begin
                  r_settle_cnt <= r_settle_cnt - 3'd1;
                  r_holding    <= 1'b1;
               end
            end
            default: begin
               r_state   <= TRACK;
               r_holding <= 1'b0;
            end
         endcase
      end
   end

   assign data_out      = r_data;
   assign data_valid    = r_valid;
   assign alpha_aligned = w_alpha_aligned;
   assign holding       = r_holding;
   assign switch_count  = r_switch_count;
   assign dbg_state     = r_state;

endmodule

// File: tb/tb_alpha_gain_combiner.sv
// Directed bench for alpha_gain_combiner with default parameters
// (ALPHA_DELAY=2, SETTLE_SAMPLES=1), strobe every 8 clk.
module tb_alpha_gain_combiner;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        enable_sampling = 1'b0;
   logic [8:0]  hdr_current_value = '0;
   logic        alpha = 1'b0;
   logic [12:0] data_out;
   logic        data_valid;
   logic        alpha_aligned;
   logic        holding;
   logic [7:0]  switch_count;
   logic        dbg_state;

   int n_cmp = 0;
   int n_bad = 0;

   alpha_gain_combiner dut (
      .clk               (clk),
      .reset             (reset),
      .enable_sampling   (enable_sampling),
      .hdr_current_value (hdr_current_value),
      .alpha             (alpha),
      .data_out          (data_out),
      .data_valid        (data_valid),
      .alpha_aligned     (alpha_aligned),
      .holding           (holding),
      .switch_count      (switch_count),
      .dbg_state         (dbg_state)
   );

   // clock
   always #5 clk = ~clk;

   // reset pulse, inputs quiet
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; enable_sampling = 1'b0; alpha = 1'b0; hdr_current_value = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // 7 idle clks, then a one-clk strobe; returns at the negedge after capture
   task automatic strobe(input int h, input logic a);
      logic [31:0] hv;
      repeat (7) @(negedge clk);
      hv = h;
      hdr_current_value = hv[8:0];
      alpha = a;
      enable_sampling = 1'b1;
      @(negedge clk);
      enable_sampling = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      strobe(50, 1'b1); strobe(50, 1'b1); strobe(50, 1'b1);
      n_cmp++; if ($signed(data_out) !== 50) begin n_bad++; $display("FAIL pre_reset_data: got %0d want 50", $signed(data_out)); end
      n_cmp++; if (holding !== 1'b1) begin n_bad++; $display("FAIL pre_reset_holding: got %b want 1", holding); end
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      n_cmp++; if (data_out !== 13'd0) begin n_bad++; $display("FAIL reset_data: got %0d want 0", $signed(data_out)); end
      n_cmp++; if (holding !== 1'b0) begin n_bad++; $display("FAIL reset_holding: got %b want 0", holding); end
      n_cmp++; if (switch_count !== 8'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", switch_count); end
      n_cmp++; if (alpha_aligned !== 1'b0) begin n_bad++; $display("FAIL reset_aligned: got %b want 0", alpha_aligned); end
      n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", data_valid); end
      @(negedge clk);
      reset = 1'b0;
      strobe(100, 1'b0);
      n_cmp++; if ($signed(data_out) !== 100) begin n_bad++; $display("FAIL first_data: got %0d want 100", $signed(data_out)); end
      n_cmp++; if (data_valid !== 1'b1) begin n_bad++; $display("FAIL first_valid_hi: got %b want 1", data_valid); end
      @(negedge clk);
      n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL first_valid_lo: got %b want 0", data_valid); end
   endtask

   task automatic test_align_settle();
      do_reset();
      strobe(20, 1'b0); strobe(20, 1'b0);
      strobe(20, 1'b1);  // strobe k
      n_cmp++; if ($signed(data_out) !== 20) begin n_bad++; $display("FAIL k_data: got %0d want 20", $signed(data_out)); end
      strobe(20, 1'b1);  // k+1
      n_cmp++; if ($signed(data_out) !== 20) begin n_bad++; $display("FAIL k1_data: got %0d want 20", $signed(data_out)); end
      n_cmp++; if (holding !== 1'b0) begin n_bad++; $display("FAIL k1_holding: got %b want 0", holding); end
      strobe(30, 1'b1);  // k+2: switch, hold previous value
      n_cmp++; if ($signed(data_out) !== 20) begin n_bad++; $display("FAIL k2_held: got %0d want 20", $signed(data_out)); end
      n_cmp++; if (holding !== 1'b1) begin n_bad++; $display("FAIL k2_holding: got %b want 1", holding); end
      n_cmp++; if (switch_count !== 8'd1) begin n_bad++; $display("FAIL k2_count: got %0d want 1", switch_count); end
      n_cmp++; if (alpha_aligned !== 1'b1) begin n_bad++; $display("FAIL k2_aligned: got %b want 1", alpha_aligned); end
      strobe(30, 1'b1);  // k+3: scaled with reduced gain
      n_cmp++; if ($signed(data_out) !== 480) begin n_bad++; $display("FAIL k3_data: got %0d want 480", $signed(data_out)); end
      n_cmp++; if (holding !== 1'b0) begin n_bad++; $display("FAIL k3_holding: got %b want 0", holding); end
   endtask

   task automatic test_extremes();
      do_reset();
      repeat (4) strobe(0, 1'b1);
      strobe(-12, 1'b1);
      n_cmp++; if ($signed(data_out) !== -192) begin n_bad++; $display("FAIL neg12_x16: got %0d want -192", $signed(data_out)); end
      strobe(-256, 1'b1);
      n_cmp++; if ($signed(data_out) !== -4096) begin n_bad++; $display("FAIL min_x16: got %0d want -4096", $signed(data_out)); end
      strobe(255, 1'b1);
      n_cmp++; if ($signed(data_out) !== 4080) begin n_bad++; $display("FAIL max_x16: got %0d want 4080", $signed(data_out)); end
      repeat (4) strobe(0, 1'b0);
      strobe(-256, 1'b0);
      n_cmp++; if ($signed(data_out) !== -256) begin n_bad++; $display("FAIL min_x1: got %0d want -256", $signed(data_out)); end
      strobe(255, 1'b0);
      n_cmp++; if ($signed(data_out) !== 255) begin n_bad++; $display("FAIL max_x1: got %0d want 255", $signed(data_out)); end
      n_cmp++; if (switch_count !== 8'd2) begin n_bad++; $display("FAIL extremes_count: got %0d want 2", switch_count); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      strobe(10, 1'b1); strobe(11, 1'b0);
      strobe(12, 1'b1);  // aligned 0->1
      n_cmp++; if ($signed(data_out) !== 11 || holding !== 1'b1) begin n_bad++; $display("FAIL b2b_s3: got %0d/%b want 11/1", $signed(data_out), holding); end
      strobe(13, 1'b1);  // aligned 1->0, reload
      n_cmp++; if ($signed(data_out) !== 11 || holding !== 1'b1) begin n_bad++; $display("FAIL b2b_s4: got %0d/%b want 11/1", $signed(data_out), holding); end
      n_cmp++; if (switch_count !== 8'd2) begin n_bad++; $display("FAIL b2b_s4_count: got %0d want 2", switch_count); end
      strobe(14, 1'b1);  // aligned 0->1, reload
      n_cmp++; if ($signed(data_out) !== 11 || holding !== 1'b1) begin n_bad++; $display("FAIL b2b_s5: got %0d/%b want 11/1", $signed(data_out), holding); end
      strobe(15, 1'b1);  // no change: release
      n_cmp++; if ($signed(data_out) !== 240 || holding !== 1'b0) begin n_bad++; $display("FAIL b2b_s6: got %0d/%b want 240/0", $signed(data_out), holding); end
      n_cmp++; if (switch_count !== 8'd3) begin n_bad++; $display("FAIL b2b_count: got %0d want 3", switch_count); end
   endtask

   task automatic test_glitch();
      do_reset();
      repeat (3) strobe(5, 1'b0);
      repeat (2) @(negedge clk);
      alpha = 1'b1;
      repeat (3) @(negedge clk);
      alpha = 1'b0;
      repeat (3) strobe(5, 1'b0);
      n_cmp++; if (alpha_aligned !== 1'b0) begin n_bad++; $display("FAIL glitch_aligned: got %b want 0", alpha_aligned); end
      n_cmp++; if (switch_count !== 8'd0) begin n_bad++; $display("FAIL glitch_count: got %0d want 0", switch_count); end
      n_cmp++; if ($signed(data_out) !== 5 || holding !== 1'b0) begin n_bad++; $display("FAIL glitch_data: got %0d/%b want 5/0", $signed(data_out), holding); end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int j = 1; j <= 302; j++) begin
         strobe(7, j[0]);
         if (j == 102) begin
            n_cmp++; if (switch_count !== 8'd100) begin n_bad++; $display("FAIL sat_mid: got %0d want 100", switch_count); end
         end
         if (j == 256) begin
            n_cmp++; if (switch_count !== 8'd254) begin n_bad++; $display("FAIL sat_254: got %0d want 254", switch_count); end
         end
         if (j == 258) begin
            n_cmp++; if (switch_count !== 8'd255) begin n_bad++; $display("FAIL sat_255: got %0d want 255", switch_count); end
         end
      end
      n_cmp++; if (switch_count !== 8'd255) begin n_bad++; $display("FAIL sat_final: got %0d want 255", switch_count); end
      n_cmp++; if ($signed(data_out) !== 7 || holding !== 1'b1) begin n_bad++; $display("FAIL sat_hold: got %0d/%b want 7/1", $signed(data_out), holding); end
   endtask

   initial begin
      test_reset();
      test_align_settle();
      test_extremes();
      test_back_to_back();
      test_glitch();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
